// File: rtl/na_wb_pkg.sv
// Shared constants and FSM state encoding for the NA Wishbone initiator.
package na_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_BUS        = 3'd1,
    S_WDATA_WAIT = 3'd2,
    S_RETRY      = 3'd3,
    S_DRAIN      = 3'd4,
    S_DONE       = 3'd5
  } state_t;

endpackage

// File: rtl/na_wb_watchdog.sv
// Ack watchdog: counts strobed cycles without any slave response.
// Only instantiated when NA_WB_INITIATOR_TIMEOUT_EN is defined.
module na_wb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stb,
  input  logic resp,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;

  assign waiting = stb && !resp;
  assign expired = waiting && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = waiting ? cnt_q + CNT_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/na_wb_initiator.sv
// Wishbone B3 burst master driven by a (adr, len, we) command stream.
// Optional ack watchdog enabled by defining NA_WB_INITIATOR_TIMEOUT_EN.
module na_wb_initiator
  import na_wb_pkg::*;
#(
  parameter int          MAX_BURST      = 16,
  parameter int          LEN_W          = $clog2(MAX_BURST + 1),
  parameter int          RETRY_WAIT     = 4,
  parameter int          MAX_RETRY      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_adr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      wdata,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  output logic [31:0]      rdata,
  output logic             rdata_valid,
  output logic             done_valid,
  output logic             done_err,
  output logic             done_timeout,
  output logic [LEN_W-1:0] done_cnt,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  output logic [3:0]       wbm_sel_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [2:0]       wbm_cti_o,
  output logic [1:0]       wbm_bte_o,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i,
  input  logic             wbm_rty_i,
  input  logic [31:0]      wbm_dat_i
);
  localparam int RTY_W  = $clog2(MAX_RETRY + 1);
  localparam int WAIT_W = $clog2(RETRY_WAIT + 1);

  state_t           state_q, state_d;
  logic [31:0]      adr_q, adr_d, dat_q, dat_d;
  logic [3:0]       sel_q, sel_d;
  logic             cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [2:0]       cti_q, cti_d;
  logic [LEN_W-1:0] len_q, len_d, beat_q, beat_d, drain_q, drain_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic             err_q, err_d, tmo_q, tmo_d;
  logic             done_valid_q, done_valid_d, done_err_q, done_err_d;
  logic             done_tmo_q, done_tmo_d;
  logic [LEN_W-1:0] done_cnt_q, done_cnt_d;
  logic             timeout_hit, abort, last_beat, next_is_last;
  logic [LEN_W-1:0] remaining;
  logic             cmd_ready_c, wdata_ready_c, rdata_valid_c;

`ifdef NA_WB_INITIATOR_TIMEOUT_EN
  na_wb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .stb     (stb_q),
    .resp    (wbm_ack_i | wbm_err_i | wbm_rty_i),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  assign last_beat    = (beat_q + LEN_W'(1)) == len_q;
  assign next_is_last = (beat_q + LEN_W'(2)) == len_q;
  // Words still queued upstream for this command, excluding the beat in flight.
  assign remaining    = len_q - beat_q - LEN_W'(1);

  always_comb begin
    state_d = state_q; adr_d = adr_q; dat_d = dat_q;
    cyc_d = cyc_q; stb_d = stb_q; we_d = we_q; cti_d = cti_q;
    len_d = len_q; beat_d = beat_q; drain_d = drain_q;
    retry_d = retry_q; wait_d = wait_q; err_d = err_q; tmo_d = tmo_q;
    cmd_ready_c = 1'b0; wdata_ready_c = 1'b0; rdata_valid_c = 1'b0;
    abort = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready_c = 1'b1;
        if (cmd_valid) begin
          beat_d = '0; retry_d = '0; err_d = 1'b0; tmo_d = 1'b0;
          len_d  = cmd_len; adr_d = cmd_adr; we_d = cmd_we;
          cti_d  = (cmd_len == LEN_W'(1)) ? CTI_EOB : CTI_INCR;
          if (cmd_len == '0 || cmd_len > LEN_W'(MAX_BURST)) begin
            err_d = 1'b1; cti_d = CTI_CLASSIC; state_d = S_DONE;
          end else if (cmd_we && !wdata_valid) begin
            state_d = S_WDATA_WAIT;
          end else begin
            if (cmd_we) begin
              wdata_ready_c = 1'b1; dat_d = wdata;
            end
            cyc_d = 1'b1; stb_d = 1'b1; state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        if (wbm_err_i || timeout_hit) begin
          abort = 1'b1; tmo_d = timeout_hit;
        end else if (wbm_rty_i) begin
          retry_d = retry_q + RTY_W'(1);
          if (retry_d == RTY_W'(MAX_RETRY)) abort = 1'b1;
          else begin
            wait_d = '0; stb_d = 1'b0; state_d = S_RETRY;
          end
        end else if (wbm_ack_i) begin
          beat_d = beat_q + LEN_W'(1); adr_d = adr_q + 32'd4;
          retry_d = '0; rdata_valid_c = !we_q;
          if (last_beat) begin
            cyc_d = 1'b0; stb_d = 1'b0; cti_d = CTI_CLASSIC; state_d = S_DONE;
          end else begin
            cti_d = next_is_last ? CTI_EOB : CTI_INCR;
            if (we_q && wdata_valid) begin
              wdata_ready_c = 1'b1; dat_d = wdata;
            end else if (we_q) begin
              stb_d = 1'b0; state_d = S_WDATA_WAIT;
            end
          end
        end
        // Error, timeout and retry exhaustion share one abort path.
        if (abort) begin
          err_d = 1'b1; cyc_d = 1'b0; stb_d = 1'b0; cti_d = CTI_CLASSIC;
          if (we_q && remaining != '0) begin
            drain_d = remaining; state_d = S_DRAIN;
          end else state_d = S_DONE;
        end
      end
      S_WDATA_WAIT: begin
        wdata_ready_c = 1'b1;
        if (wdata_valid) begin
          dat_d = wdata; cyc_d = 1'b1; stb_d = 1'b1; state_d = S_BUS;
        end
      end
      S_RETRY: begin
        if (wait_q == WAIT_W'(RETRY_WAIT - 1)) begin
          stb_d = 1'b1; state_d = S_BUS;
        end else wait_d = wait_q + WAIT_W'(1);
      end
      S_DRAIN: begin
        wdata_ready_c = 1'b1;
        if (wdata_valid) begin
          drain_d = drain_q - LEN_W'(1);
          if (drain_q == LEN_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    sel_d        = stb_d ? 4'hF : 4'h0;
    done_valid_d = (state_d == S_DONE);
    done_err_d   = done_err_q;
    done_tmo_d   = done_tmo_q;
    done_cnt_d   = done_cnt_q;
    if (state_d == S_DONE) begin
      done_err_d = err_d; done_tmo_d = tmo_d; done_cnt_d = beat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE; adr_q <= '0; dat_q <= '0; sel_q <= '0;
      cyc_q <= 1'b0; stb_q <= 1'b0; we_q <= 1'b0; cti_q <= CTI_CLASSIC;
      len_q <= '0; beat_q <= '0; drain_q <= '0; retry_q <= '0; wait_q <= '0;
      err_q <= 1'b0; tmo_q <= 1'b0;
      done_valid_q <= 1'b0; done_err_q <= 1'b0; done_tmo_q <= 1'b0; done_cnt_q <= '0;
    end else begin
      state_q <= state_d; adr_q <= adr_d; dat_q <= dat_d; sel_q <= sel_d;
      cyc_q <= cyc_d; stb_q <= stb_d; we_q <= we_d; cti_q <= cti_d;
      len_q <= len_d; beat_q <= beat_d; drain_q <= drain_d;
      retry_q <= retry_d; wait_q <= wait_d; err_q <= err_d; tmo_q <= tmo_d;
      done_valid_q <= done_valid_d; done_err_q <= done_err_d;
      done_tmo_q <= done_tmo_d; done_cnt_q <= done_cnt_d;
    end
  end

  // Handshake outputs are held low while reset is asserted.
  assign cmd_ready    = rst_n && cmd_ready_c;
  assign wdata_ready  = rst_n && wdata_ready_c;
  assign rdata_valid  = rst_n && rdata_valid_c;
  assign rdata        = rdata_valid ? wbm_dat_i : 32'h0;
  assign done_valid   = done_valid_q;
  assign done_err     = done_err_q;
  assign done_timeout = done_tmo_q;
  assign done_cnt     = done_cnt_q;
  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = dat_q;
  assign wbm_sel_o    = sel_q;
  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = stb_q;
  assign wbm_we_o     = we_q;
  assign wbm_cti_o    = cti_q;
  assign wbm_bte_o    = BTE_LINEAR;
endmodule

// File: tb/tb_na_wb_initiator.sv
// Directed self-checking bench for na_wb_initiator with a combinational slave.
// The watchdog scenario runs only when NA_WB_INITIATOR_TIMEOUT_EN is defined.
module tb_na_wb_initiator;
  localparam int LEN_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, cmd_valid, cmd_ready, cmd_we;
  logic [31:0]      cmd_adr, wdata, rdata;
  logic [LEN_W-1:0] cmd_len, done_cnt;
  logic             wdata_valid, wdata_ready, rdata_valid;
  logic             done_valid, done_err, done_timeout;
  logic [31:0]      wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]       wbm_sel_o;
  logic             wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [2:0]       wbm_cti_o;
  logic [1:0]       wbm_bte_o;
  logic             wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic             ack_en, err_en, rty_en;

  int checks = 0;
  int errors = 0;

  // Slave responds in the same cycle as stb; read data is a function of address.
  assign wbm_ack_i = wbm_stb_o & ack_en;
  assign wbm_err_i = wbm_stb_o & err_en;
  assign wbm_rty_i = wbm_stb_o & rty_en;
  assign wbm_dat_i = 32'hA500_0000 | wbm_adr_o;

  na_wb_initiator dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid),
    .done_valid(done_valid), .done_err(done_err), .done_timeout(done_timeout),
    .done_cnt(done_cnt),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .wbm_dat_i(wbm_dat_i)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic we,
                               input logic [31:0] adr, input logic [LEN_W-1:0] len);
    cmd_valid = valid;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_len   = len;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0; wdata = '0; wdata_valid = 1'b0;
    ack_en = 1'b0; err_en = 1'b0; rty_en = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, '0);

    // Reset state
    cycle(); settle();
    checkOutput("rst_cmd_ready", cmd_ready, 1'b0);
    checkOutput("rst_cyc", wbm_cyc_o, 1'b0);
    checkOutput("rst_done_valid", done_valid, 1'b0);
    cycle(); rst_n = 1'b1; settle();
    checkOutput("idle_cmd_ready", cmd_ready, 1'b1);

    // Read burst of 4 with ack every cycle
    cycle(); applyStimulus(1'b1, 1'b0, 32'h100, 5'd4); ack_en = 1'b1; settle();
    checkOutput("rd_accept", cmd_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(); cmd_valid = 1'b0; settle();
      checkOutput("rd_adr", wbm_adr_o, 32'h100 + 32'(4 * i));
      checkOutput("rd_cti", wbm_cti_o, (i == 3) ? 3'b111 : 3'b010);
      checkOutput("rd_cyc", wbm_cyc_o, 1'b1);
      checkOutput("rd_sel", wbm_sel_o, 4'hF);
      checkOutput("rd_valid", rdata_valid, 1'b1);
      checkOutput("rd_data", rdata, 32'hA500_0100 + 32'(4 * i));
    end
    cycle(); settle();
    checkOutput("rd_done_valid", done_valid, 1'b1);
    checkOutput("rd_done_cnt", done_cnt, 5'd4);
    checkOutput("rd_done_err", done_err, 1'b0);
    checkOutput("rd_done_cyc", wbm_cyc_o, 1'b0);
    cycle(); settle();
    checkOutput("rd_done_pulse", done_valid, 1'b0);

    // Write of 3 with a 5-cycle data gap after beat 1
    cycle(); applyStimulus(1'b1, 1'b1, 32'h200, 5'd3);
    wdata_valid = 1'b1; wdata = 32'h1111_0000; settle();
    checkOutput("wr_first_ready", wdata_ready, 1'b1);
    cycle(); cmd_valid = 1'b0; wdata_valid = 1'b0; settle();
    checkOutput("wr_b0_stb", wbm_stb_o, 1'b1);
    checkOutput("wr_b0_dat", wbm_dat_o, 32'h1111_0000);
    checkOutput("wr_b0_we", wbm_we_o, 1'b1);
    checkOutput("wr_b0_cti", wbm_cti_o, 3'b010);
    for (int i = 0; i < 4; i++) begin
      cycle(); settle();
      checkOutput("wr_gap_stb", wbm_stb_o, 1'b0);
      checkOutput("wr_gap_cyc", wbm_cyc_o, 1'b1);
    end
    cycle(); wdata_valid = 1'b1; wdata = 32'h2222_0001; settle();
    checkOutput("wr_gap_ready", wdata_ready, 1'b1);
    checkOutput("wr_gap_end_stb", wbm_stb_o, 1'b0);
    cycle(); wdata = 32'h3333_0002; settle();
    checkOutput("wr_b1_adr", wbm_adr_o, 32'h204);
    checkOutput("wr_b1_dat", wbm_dat_o, 32'h2222_0001);
    checkOutput("wr_b1_cti", wbm_cti_o, 3'b010);
    checkOutput("wr_b1_ready", wdata_ready, 1'b1);
    cycle(); wdata_valid = 1'b0; settle();
    checkOutput("wr_b2_adr", wbm_adr_o, 32'h208);
    checkOutput("wr_b2_dat", wbm_dat_o, 32'h3333_0002);
    checkOutput("wr_b2_cti", wbm_cti_o, 3'b111);
    cycle(); settle();
    checkOutput("wr_done_valid", done_valid, 1'b1);
    checkOutput("wr_done_cnt", done_cnt, 5'd3);
    checkOutput("wr_done_err", done_err, 1'b0);
    cycle();

    // Read of 3 with two retries on beat 2
    applyStimulus(1'b1, 1'b0, 32'h300, 5'd3); settle();
    cycle(); cmd_valid = 1'b0; settle();
    checkOutput("rty_b0_valid", rdata_valid, 1'b1);
    cycle(); ack_en = 1'b0; rty_en = 1'b1; settle();
    checkOutput("rty_b1_adr", wbm_adr_o, 32'h304);
    checkOutput("rty_b1_valid", rdata_valid, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int w = 0; w < 4; w++) begin
        cycle(); settle();
        checkOutput("rty_wait_stb", wbm_stb_o, 1'b0);
        checkOutput("rty_wait_cyc", wbm_cyc_o, 1'b1);
      end
      cycle();
      if (r == 1) begin
        ack_en = 1'b1; rty_en = 1'b0;
      end
      settle();
      checkOutput("rty_reissue_stb", wbm_stb_o, 1'b1);
      checkOutput("rty_reissue_adr", wbm_adr_o, 32'h304);
      checkOutput("rty_reissue_valid", rdata_valid, (r == 1));
    end
    cycle(); settle();
    checkOutput("rty_b2_adr", wbm_adr_o, 32'h308);
    checkOutput("rty_b2_cti", wbm_cti_o, 3'b111);
    checkOutput("rty_b2_data", rdata, 32'hA500_0308);
    cycle(); settle();
    checkOutput("rty_done_valid", done_valid, 1'b1);
    checkOutput("rty_done_err", done_err, 1'b0);
    checkOutput("rty_done_cnt", done_cnt, 5'd3);
    cycle();

    // Write of 4 with err on beat 2, drain, then a clean single write
    applyStimulus(1'b1, 1'b1, 32'h400, 5'd4);
    wdata_valid = 1'b1; wdata = 32'h4444_0000; settle();
    cycle(); cmd_valid = 1'b0; wdata = 32'h4444_0001; settle();
    checkOutput("err_b0_dat", wbm_dat_o, 32'h4444_0000);
    checkOutput("err_b0_ready", wdata_ready, 1'b1);
    cycle(); wdata_valid = 1'b0; ack_en = 1'b0; err_en = 1'b1; settle();
    checkOutput("err_b1_dat", wbm_dat_o, 32'h4444_0001);
    checkOutput("err_b1_ready", wdata_ready, 1'b0);
    cycle(); err_en = 1'b0; ack_en = 1'b1; wdata_valid = 1'b1; wdata = 32'h4444_0002; settle();
    checkOutput("drain_cyc", wbm_cyc_o, 1'b0);
    checkOutput("drain_ready0", wdata_ready, 1'b1);
    cycle(); wdata = 32'h4444_0003; settle();
    checkOutput("drain_ready1", wdata_ready, 1'b1);
    checkOutput("drain_no_done", done_valid, 1'b0);
    cycle(); wdata_valid = 1'b0; settle();
    checkOutput("err_done_valid", done_valid, 1'b1);
    checkOutput("err_done_err", done_err, 1'b1);
    checkOutput("err_done_cnt", done_cnt, 5'd1);
    checkOutput("err_done_tmo", done_timeout, 1'b0);
    cycle(); applyStimulus(1'b1, 1'b1, 32'h500, 5'd1);
    wdata_valid = 1'b1; wdata = 32'h5555_AAAA; settle();
    checkOutput("next_accept", cmd_ready, 1'b1);
    cycle(); cmd_valid = 1'b0; wdata_valid = 1'b0; settle();
    checkOutput("next_dat", wbm_dat_o, 32'h5555_AAAA);
    checkOutput("next_adr", wbm_adr_o, 32'h500);
    checkOutput("next_cti", wbm_cti_o, 3'b111);
    cycle(); settle();
    checkOutput("next_done_err", done_err, 1'b0);
    checkOutput("next_done_cnt", done_cnt, 5'd1);
    cycle();

    // Illegal lengths 0 and 17
    applyStimulus(1'b1, 1'b0, 32'h600, 5'd0); settle();
    cycle(); cmd_valid = 1'b0; settle();
    checkOutput("len0_cyc", wbm_cyc_o, 1'b0);
    checkOutput("len0_done", done_valid, 1'b1);
    checkOutput("len0_err", done_err, 1'b1);
    checkOutput("len0_cnt", done_cnt, 5'd0);
    cycle(); applyStimulus(1'b1, 1'b0, 32'h600, 5'd17); settle();
    checkOutput("len17_accept", cmd_ready, 1'b1);
    cycle(); cmd_valid = 1'b0; settle();
    checkOutput("len17_cyc", wbm_cyc_o, 1'b0);
    checkOutput("len17_done", done_valid, 1'b1);
    checkOutput("len17_err", done_err, 1'b1);
    cycle();

    // Retry exhaustion: eighth rty on the same beat aborts the command
    applyStimulus(1'b1, 1'b0, 32'h700, 5'd1); ack_en = 1'b0; rty_en = 1'b1; settle();
    for (int i = 0; i < 36; i++) begin
      cycle(); cmd_valid = 1'b0; settle();
    end
    checkOutput("rtymax_last_stb", wbm_stb_o, 1'b1);
    checkOutput("rtymax_last_adr", wbm_adr_o, 32'h700);
    cycle(); settle();
    checkOutput("rtymax_done", done_valid, 1'b1);
    checkOutput("rtymax_err", done_err, 1'b1);
    checkOutput("rtymax_cnt", done_cnt, 5'd0);
    checkOutput("rtymax_cyc", wbm_cyc_o, 1'b0);
    cycle(); rty_en = 1'b0; ack_en = 1'b1;

    // Reset in the middle of a burst
    applyStimulus(1'b1, 1'b0, 32'h800, 5'd4); settle();
    cycle(); cmd_valid = 1'b0; settle();
    checkOutput("mid_adr", wbm_adr_o, 32'h800);
    cycle(); rst_n = 1'b0; settle();
    cycle(); settle();
    checkOutput("mid_rst_cyc", wbm_cyc_o, 1'b0);
    checkOutput("mid_rst_stb", wbm_stb_o, 1'b0);
    checkOutput("mid_rst_adr", wbm_adr_o, 32'h0);
    checkOutput("mid_rst_cti", wbm_cti_o, 3'b000);
    checkOutput("mid_rst_done", done_valid, 1'b0);
    checkOutput("mid_rst_ready", cmd_ready, 1'b0);
    rst_n = 1'b1;
    cycle(); settle();
    checkOutput("post_rst_done", done_valid, 1'b0);
    checkOutput("post_rst_ready", cmd_ready, 1'b1);

`ifdef NA_WB_INITIATOR_TIMEOUT_EN
    // Slave never responds: watchdog aborts after 1024 strobed cycles
    ack_en = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h900, 5'd1); settle();
    for (int i = 0; i < 1024; i++) begin
      cycle(); cmd_valid = 1'b0; settle();
    end
    checkOutput("tmo_last_stb", wbm_stb_o, 1'b1);
    cycle(); settle();
    checkOutput("tmo_done", done_valid, 1'b1);
    checkOutput("tmo_flag", done_timeout, 1'b1);
    checkOutput("tmo_err", done_err, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
